// File: rtl/display_pkg.sv
// Shared constants for the 7-segment display driver: digit count, blank
// patterns and the active-low hex-to-segment table (bit 6 = g ... bit 0 = a).
package display_pkg;
  localparam int         NUM_DIGITS = 8;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [7:0] AN_OFF     = 8'hFF;

  // Indexed by nibble value; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };
endpackage

// File: rtl/seg_display_if.sv
// Connection between the cpu outputs and the board display driver.
interface seg_display_if;
  logic [31:0] display;
  logic [31:0] cycle_count;
  logic        halt;
  logic        sel;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport slave  (input display, cycle_count, halt, sel, output an, seg, dp);
  modport master (output display, cycle_count, halt, sel, input an, seg, dp);
endinterface

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low 7-segment pattern.
module hex_to_seg
  import display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = HEX_SEG[nib];
endmodule

// File: rtl/seg_display.sv
// Time-multiplexed 8-digit hex display with per-frame input capture and
// a permanent freeze of both captured values once halt is seen.
module seg_display
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic          clk,
  input  logic          clr,
  seg_display_if.slave  bus
);
  localparam int                DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       digit;
  logic             tick, frame;
  logic [31:0]      snap_disp, snap_cyc, v;
  logic             halted;
  logic [3:0]       nib;
  logic [6:0]       seg_d;

  assign tick  = (div_cnt == DIV_MAX);
  assign frame = tick && (digit == 3'd7);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      div_cnt <= '0;
      digit   <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      digit   <= digit + 3'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Once halted, nothing but reset touches the snapshots again.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      snap_disp <= '0;
      snap_cyc  <= '0;
      halted    <= 1'b0;
    end else if (!halted) begin
      if (bus.halt || frame) begin
        snap_disp <= bus.display;
        snap_cyc  <= bus.cycle_count;
      end
      if (bus.halt) halted <= 1'b1;
    end
  end

  assign v   = bus.sel ? snap_cyc : snap_disp;
  assign nib = v[{digit, 2'b00} +: 4];

  hex_to_seg u_dec (
    .nib (nib),
    .seg (seg_d)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      bus.an  <= AN_OFF;
      bus.seg <= SEG_BLANK;
      bus.dp  <= 1'b1;
    end else begin
      bus.an  <= ~(NUM_DIGITS'(1) << digit);
      bus.seg <= seg_d;
      bus.dp  <= ~halted;
    end
  end
endmodule

// File: tb/tb_seg_display.sv
// Directed bench for seg_display at SCAN_DIV=4: stimulus queues expected
// outputs, a monitor pops and compares them on the falling edge.
module tb_seg_display;
  import display_pkg::*;

  localparam int SD = 4;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  localparam logic [7:0][7:0] AN_TAB  = {8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
  localparam logic [7:0][6:0] T_ZERO  = {8{7'h40}};
  localparam logic [7:0][6:0] T_F     = {8{7'h0E}};
  // 1234ABCD, digit 0 (D) rightmost
  localparam logic [7:0][6:0] T_1234  = {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21};
  // 00000010
  localparam logic [7:0][6:0] T_C10   = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h40};

  logic clk = 1'b0;
  logic clr = 1'b0;
  seg_display_if bus ();

  seg_display #(.SCAN_DIV(SD)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   e = 0;
  int   nvec = 0;
  int   nerr = 0;
  event mon_ev;

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk or mon_ev);
      if (q.size() > 0) begin
        x = q.pop_front();
        nvec++;
        if ({bus.an, bus.seg, bus.dp} !== x) begin
          nerr++;
          $display("FAIL scan e=%0d t=%0t: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                   e, $time, bus.an, bus.seg, bus.dp, x.an, x.seg, x.dp);
        end
      end
    end
  end

  task automatic adv();
    @(posedge clk); #1;
    e++;
  endtask

  task automatic exp_blank();
    q.push_back('{an: 8'hFF, seg: 7'h7F, dp: 1'b1});
  endtask

  task automatic exp_scan(input logic [7:0][6:0] tab, input logic d);
    int dg;
    dg = ((e - 1) / SD) % 8;
    q.push_back('{an: AN_TAB[dg], seg: tab[dg], dp: d});
  endtask

  initial begin : stim
    bus.display     = 32'h1234ABCD;
    bus.cycle_count = 32'h0;
    bus.halt        = 1'b0;
    bus.sel         = 1'b0;

    repeat (3) begin @(posedge clk); #1; exp_blank(); end
    clr = 1'b1;
    e   = 0;

    repeat (32) begin adv(); exp_scan(T_ZERO, 1'b1); end      // frame 0: reset snapshot
    repeat (8)  begin adv(); exp_scan(T_1234, 1'b1); end      // frame 1 starts
    bus.display = 32'hFFFFFFFF;                              // mid-frame change
    repeat (24) begin adv(); exp_scan(T_1234, 1'b1); end
    repeat (36) begin adv(); exp_scan(T_F, 1'b1); end         // frame 2 + start of frame 3

    bus.cycle_count = 32'h00000010;
    bus.halt        = 1'b1;
    bus.sel         = 1'b1;
    adv(); exp_scan(T_ZERO, 1'b1);                           // capture edge: old snap_cyc
    bus.halt        = 1'b0;
    bus.cycle_count = 32'hFFFFFFFF;
    bus.display     = 32'h12345678;
    repeat (31) begin adv(); exp_scan(T_C10, 1'b0); end       // frozen across boundary
    bus.sel = 1'b0;
    repeat (4)  begin adv(); exp_scan(T_F, 1'b0); end
    bus.sel = 1'b1;
    repeat (4)  begin adv(); exp_scan(T_C10, 1'b0); end
    bus.sel = 1'b0;
    adv(); exp_scan(T_F, 1'b0);

    // Asynchronous reset between edges
    @(negedge clk); #2;
    clr = 1'b0;
    #1;
    exp_blank();
    ->mon_ev;
    repeat (2) begin @(posedge clk); #1; exp_blank(); end
    clr     = 1'b1;
    bus.sel = 1'b1;
    e       = 0;
    repeat (32) begin adv(); exp_scan(T_ZERO, 1'b1); end     // snapshots and halted cleared
    repeat (4)  begin adv(); exp_scan(T_F, 1'b1); end        // capture works again

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d expected entries left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
